light_sequence_monitor: RTL and testbench

//  Safety monitor that consumes the 2-bit traffic-light code (00=Red, 01=Yellow,
//  10=Green) produced by the light controller. Legal cycle is Red->Yellow->Green->Red.

---
 rtl/light_sequence_monitor_if.sv | 28 ++
 rtl/light_sequence_monitor.sv | 167 ++++++++++++++++
 tb/tb_light_sequence_monitor.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/light_sequence_monitor_if.sv
// Signal bundle between the light controller side and the sequence monitor.
// The controller drives the observed code and qualifiers; the monitor returns status.
interface light_sequence_monitor_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CYC_W = 16
) ();
  logic [1:0]       light_in;
  logic             en;
  logic             clear_fault;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] dwell;
  logic [CYC_W-1:0] cycles;
  logic             fault;
  logic [2:0]       fault_code;
  logic             err_pulse;
  logic             safe_to_cross;

  modport master (
    output light_in, en, clear_fault,
    input  phase, phase_valid, dwell, cycles, fault, fault_code, err_pulse, safe_to_cross
  );

  modport slave (
    input  light_in, en, clear_fault,
    output phase, phase_valid, dwell, cycles, fault, fault_code, err_pulse, safe_to_cross
  );
endinterface

// File: rtl/light_sequence_monitor.sv
// Traffic-light sequence safety monitor: checks codes, Red->Yellow->Green order and dwell
// limits, latches a sticky fault, counts completed cycles and drives the crossing enable.
module light_sequence_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  light_sequence_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] C_RED = 2'b00;
  localparam logic [1:0] C_YEL = 2'b01;
  localparam logic [1:0] C_GRN = 2'b10;
  localparam logic [1:0] C_BAD = 2'b11;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_BADTRAN = 3'd2;
  localparam logic [2:0] FC_SHORT   = 3'd3;
  localparam logic [2:0] FC_TIMEOUT = 3'd4;

  localparam logic [CNT_W-1:0] L_MIN_DWELL = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] L_MAX_DWELL = CNT_W'(MAX_DWELL);

  state_t           r_state, w_state;
  logic [1:0]       r_phase, w_phase;
  logic             r_phase_valid, w_phase_valid;
  logic [CNT_W-1:0] r_dwell, w_dwell;
  logic [CYC_W-1:0] r_cycles, w_cycles;
  logic             r_fault, w_fault;
  logic [2:0]       r_fault_code, w_fault_code;
  logic             r_err_pulse, w_err_pulse;
  logic             r_safe, w_safe;
  logic             w_hit;
  logic [2:0]       w_hit_code;
  logic [1:0]       w_succ;

  // Next-state and next-output logic; a detected violation is folded in after the case.
  always_comb begin
    w_state       = r_state;
    w_phase       = r_phase;
    w_phase_valid = r_phase_valid;
    w_dwell       = r_dwell;
    w_cycles      = r_cycles;
    w_fault       = r_fault;
    w_fault_code  = r_fault_code;
    w_err_pulse   = 1'b0;
    w_hit         = 1'b0;
    w_hit_code    = FC_NONE;
    w_succ        = (r_phase == C_RED) ? C_YEL :
                    (r_phase == C_YEL) ? C_GRN : C_RED;

    unique case (r_state)
      ST_INIT: begin
        if (bus.en) begin
          if (bus.light_in == C_BAD) begin
            w_hit      = 1'b1;
            w_hit_code = FC_ILLEGAL;
          end else begin
            w_phase       = bus.light_in;
            w_phase_valid = 1'b1;
            w_dwell       = CNT_W'(1);
            w_state       = ST_TRACK;
          end
        end
      end
      ST_TRACK: begin
        if (bus.en) begin
          if (bus.light_in == C_BAD) begin
            w_hit      = 1'b1;
            w_hit_code = FC_ILLEGAL;
          end else if (bus.light_in == r_phase) begin
            if (r_dwell == L_MAX_DWELL) begin
              w_hit      = 1'b1;
              w_hit_code = FC_TIMEOUT;
            end else begin
              w_dwell = r_dwell + CNT_W'(1);
            end
          end else if (bus.light_in != w_succ) begin
            w_hit      = 1'b1;
            w_hit_code = FC_BADTRAN;
          end else if (r_dwell < L_MIN_DWELL) begin
            w_hit      = 1'b1;
            w_hit_code = FC_SHORT;
          end else begin
            // Only Green->Red closes a full light cycle.
            if (r_phase == C_GRN && bus.light_in == C_RED) begin
              w_cycles = r_cycles + CYC_W'(1);
            end
            w_phase = bus.light_in;
            w_dwell = CNT_W'(1);
          end
        end
      end
      ST_FAULT: begin
        if (bus.clear_fault) begin
          w_state       = ST_INIT;
          w_fault       = 1'b0;
          w_fault_code  = FC_NONE;
          w_phase_valid = 1'b0;
          w_dwell       = '0;
        end
      end
      default: begin
        w_state = ST_INIT;
      end
    endcase

    // Tracking registers keep their pre-fault values; only the fault status changes.
    if (w_hit) begin
      w_state       = ST_FAULT;
      w_fault       = 1'b1;
      w_fault_code  = w_hit_code;
      w_err_pulse   = 1'b1;
      w_phase       = r_phase;
      w_phase_valid = r_phase_valid;
      w_dwell       = r_dwell;
      w_cycles      = r_cycles;
    end

    w_safe = w_phase_valid & (w_phase == C_RED) & ~w_fault;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_INIT;
      r_phase       <= C_RED;
      r_phase_valid <= 1'b0;
      r_dwell       <= '0;
      r_cycles      <= '0;
      r_fault       <= 1'b0;
      r_fault_code  <= FC_NONE;
      r_err_pulse   <= 1'b0;
      r_safe        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_phase       <= w_phase;
      r_phase_valid <= w_phase_valid;
      r_dwell       <= w_dwell;
      r_cycles      <= w_cycles;
      r_fault       <= w_fault;
      r_fault_code  <= w_fault_code;
      r_err_pulse   <= w_err_pulse;
      r_safe        <= w_safe;
    end
  end

  assign bus.phase         = r_phase;
  assign bus.phase_valid   = r_phase_valid;
  assign bus.dwell         = r_dwell;
  assign bus.cycles        = r_cycles;
  assign bus.fault         = r_fault;
  assign bus.fault_code    = r_fault_code;
  assign bus.err_pulse     = r_err_pulse;
  assign bus.safe_to_cross = r_safe;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Bench for light_sequence_monitor: two configurations (default, and short-dwell/narrow-counter)
// driven with identical stimulus and compared against a rule-level reference model.
module tb_light_sequence_monitor;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  light_sequence_monitor_if #(.CNT_W(8), .CYC_W(16)) if_a ();
  light_sequence_monitor_if #(.CNT_W(4), .CYC_W(2))  if_b ();

  light_sequence_monitor #(.CNT_W(8), .CYC_W(16), .MIN_DWELL(1), .MAX_DWELL(255)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  light_sequence_monitor #(.CNT_W(4), .CYC_W(2), .MIN_DWELL(2), .MAX_DWELL(8)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  typedef struct {
    int phase;
    bit valid;
    int dwell;
    int cycles;
    bit fault;
    int code;
    bit pulse;
  } model_t;

  model_t ma, mb;

  // One sample of the monitoring rules, expressed directly on light colours.
  function automatic model_t step(model_t m, int min_d, int max_d, int cyc_mod,
                                  int light, bit en, bit clr, bit rst);
    model_t n = m;
    int code = 0;
    n.pulse = 0;
    if (rst) begin
      n = '{0, 0, 0, 0, 0, 0, 0};
      return n;
    end
    if (m.fault) begin
      if (clr) begin
        n.fault = 0; n.code = 0; n.valid = 0; n.dwell = 0;
      end
      return n;
    end
    if (!en) return n;
    if (light == 3) code = 1;
    else if (!m.valid) begin
      n.phase = light; n.valid = 1; n.dwell = 1;
    end else if (light == m.phase) begin
      if (m.dwell == max_d) code = 4;
      else n.dwell = m.dwell + 1;
    end else if (light != (m.phase + 1) % 3) code = 2;
    else if (m.dwell < min_d) code = 3;
    else begin
      if (m.phase == 2) n.cycles = (m.cycles + 1) % cyc_mod;
      n.phase = light; n.dwell = 1;
    end
    if (code != 0) begin
      n.fault = 1; n.code = code; n.pulse = 1;
    end
    return n;
  endfunction

  function automatic bit safe_of(model_t m);
    return m.valid && (m.phase == 0) && !m.fault;
  endfunction

  task automatic drive(input int light, input bit en, input bit clr, input bit rst);
    if_a.light_in = 2'(light); if_a.en = en; if_a.clear_fault = clr;
    if_b.light_in = 2'(light); if_b.en = en; if_b.clear_fault = clr;
    reset = rst;
    @(posedge clk);
    ma = step(ma, 1, 255, 65536, light, en, clr, rst);
    mb = step(mb, 2, 8, 4, light, en, clr, rst);
    #1;
  endtask

  task automatic test_reset();
    drive(3, 1, 1, 1);
    drive(2, 1, 0, 1);
    n_checks++;
    if ({if_a.phase, if_a.phase_valid, if_a.dwell, if_a.cycles, if_a.fault, if_a.fault_code,
         if_a.err_pulse, if_a.safe_to_cross} !== 33'h0) begin
      n_fail++; $display("FAIL reset_a: got phase=%0d valid=%0b dwell=%0d cycles=%0d fault=%0b code=%0d, want all 0",
                         if_a.phase, if_a.phase_valid, if_a.dwell, if_a.cycles, if_a.fault, if_a.fault_code);
    end
    n_checks++;
    if ({if_b.phase, if_b.phase_valid, if_b.dwell, if_b.cycles, if_b.fault, if_b.fault_code,
         if_b.err_pulse, if_b.safe_to_cross} !== 15'h0) begin
      n_fail++; $display("FAIL reset_b: got dwell=%0d fault=%0b code=%0d, want all 0",
                         if_b.dwell, if_b.fault, if_b.fault_code);
    end
  endtask

  task automatic test_full_cycles();
    int seq[9] = '{0, 0, 1, 2, 0, 0, 1, 2, 0};
    drive(0, 0, 0, 1);
    foreach (seq[i]) begin
      drive(seq[i], 1, 0, 0);
      if (i == 3) begin
        n_checks++;
        if (if_b.fault_code !== 3'd3 || if_b.phase !== 2'd1 || if_b.dwell !== 4'd1) begin
          n_fail++; $display("FAIL short_dwell_b: got code=%0d phase=%0d dwell=%0d, want 3/1/1",
                             if_b.fault_code, if_b.phase, if_b.dwell);
        end
      end
    end
    n_checks++;
    if (if_a.fault !== 1'b0 || if_a.cycles !== 16'd2 || if_a.phase !== 2'd0 ||
        if_a.dwell !== 8'd1 || if_a.safe_to_cross !== 1'b1) begin
      n_fail++; $display("FAIL full_cycles_a: got fault=%0b cycles=%0d phase=%0d dwell=%0d safe=%0b, want 0/2/0/1/1",
                         if_a.fault, if_a.cycles, if_a.phase, if_a.dwell, if_a.safe_to_cross);
    end
  endtask

  task automatic test_illegal_code();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(3, 1, 0, 0);
    n_checks++;
    if (if_a.err_pulse !== 1'b1 || if_a.fault !== 1'b1 || if_a.fault_code !== 3'd1 ||
        if_a.phase !== 2'd1 || if_a.dwell !== 8'd1) begin
      n_fail++; $display("FAIL illegal_code: got pulse=%0b fault=%0b code=%0d phase=%0d dwell=%0d, want 1/1/1/1/1",
                         if_a.err_pulse, if_a.fault, if_a.fault_code, if_a.phase, if_a.dwell);
    end
    drive(2, 1, 0, 0);
    drive(0, 1, 0, 0);
    n_checks++;
    if (if_a.err_pulse !== 1'b0 || if_a.fault_code !== 3'd1 || if_a.phase !== 2'd1 || if_a.dwell !== 8'd1) begin
      n_fail++; $display("FAIL fault_frozen: got pulse=%0b code=%0d phase=%0d dwell=%0d, want 0/1/1/1",
                         if_a.err_pulse, if_a.fault_code, if_a.phase, if_a.dwell);
    end
    drive(0, 1, 1, 0);
    n_checks++;
    if (if_a.phase_valid !== 1'b0 || if_a.fault !== 1'b0 || if_a.fault_code !== 3'd0 || if_a.dwell !== 8'd0) begin
      n_fail++; $display("FAIL clear_fault: got valid=%0b fault=%0b code=%0d dwell=%0d, want 0/0/0/0",
                         if_a.phase_valid, if_a.fault, if_a.fault_code, if_a.dwell);
    end
    drive(2, 1, 0, 0);
    n_checks++;
    if (if_a.phase_valid !== 1'b1 || if_a.phase !== 2'd2 || if_a.dwell !== 8'd1 || if_a.fault !== 1'b0) begin
      n_fail++; $display("FAIL reacquire: got valid=%0b phase=%0d dwell=%0d fault=%0b, want 1/2/1/0",
                         if_a.phase_valid, if_a.phase, if_a.dwell, if_a.fault);
    end
  endtask

  task automatic test_bad_transition();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(2, 1, 0, 0);
    n_checks++;
    if (if_a.fault_code !== 3'd2 || if_a.phase !== 2'd0 || if_a.dwell !== 8'd2 || if_a.safe_to_cross !== 1'b0) begin
      n_fail++; $display("FAIL bad_transition: got code=%0d phase=%0d dwell=%0d safe=%0b, want 2/0/2/0",
                         if_a.fault_code, if_a.phase, if_a.dwell, if_a.safe_to_cross);
    end
  endtask

  task automatic test_timeout();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    drive(1, 1, 0, 0); drive(1, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      drive(2, 1, 0, 0);
      if (i == 8) begin
        n_checks++;
        if (if_b.dwell !== 4'd8 || if_b.fault !== 1'b0) begin
          n_fail++; $display("FAIL dwell_max: got dwell=%0d fault=%0b, want 8/0", if_b.dwell, if_b.fault);
        end
      end
    end
    n_checks++;
    if (if_b.fault_code !== 3'd4 || if_b.dwell !== 4'd8 || if_b.err_pulse !== 1'b1) begin
      n_fail++; $display("FAIL timeout: got code=%0d dwell=%0d pulse=%0b, want 4/8/1",
                         if_b.fault_code, if_b.dwell, if_b.err_pulse);
    end
  endtask

  task automatic test_en_gating();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(int'($urandom_range(0, 3)), 0, 0, 0);
    n_checks++;
    if (if_a.dwell !== 8'd2 || if_a.fault !== 1'b0 || if_a.err_pulse !== 1'b0 || if_a.safe_to_cross !== 1'b1) begin
      n_fail++; $display("FAIL en_gating: got dwell=%0d fault=%0b pulse=%0b safe=%0b, want 2/0/0/1",
                         if_a.dwell, if_a.fault, if_a.err_pulse, if_a.safe_to_cross);
    end
    drive(0, 1, 1, 0);
    n_checks++;
    if (if_a.dwell !== 8'd3 || if_a.fault !== 1'b0 || if_a.phase_valid !== 1'b1) begin
      n_fail++; $display("FAIL clear_outside_fault: got dwell=%0d fault=%0b valid=%0b, want 3/0/1",
                         if_a.dwell, if_a.fault, if_a.phase_valid);
    end
  endtask

  task automatic test_cycle_wrap();
    drive(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0); drive(0, 1, 0, 0);
      drive(1, 1, 0, 0); drive(1, 1, 0, 0);
      drive(2, 1, 0, 0); drive(2, 1, 0, 0);
    end
    drive(0, 1, 0, 0);
    n_checks++;
    if (if_b.cycles !== 2'd1 || if_b.fault !== 1'b0) begin
      n_fail++; $display("FAIL cycle_wrap_b: got cycles=%0d fault=%0b, want 1/0", if_b.cycles, if_b.fault);
    end
    n_checks++;
    if (if_a.cycles !== 16'd5) begin
      n_fail++; $display("FAIL cycle_count_a: got cycles=%0d, want 5", if_a.cycles);
    end
  endtask

  task automatic test_reset_in_fault();
    drive(3, 1, 0, 0);
    drive(0, 1, 1, 1);
    n_checks++;
    if ({if_a.phase, if_a.phase_valid, if_a.dwell, if_a.cycles, if_a.fault, if_a.fault_code,
         if_a.err_pulse, if_a.safe_to_cross} !== 33'h0) begin
      n_fail++; $display("FAIL reset_in_fault: got valid=%0b dwell=%0d cycles=%0d fault=%0b code=%0d, want all 0",
                         if_a.phase_valid, if_a.dwell, if_a.cycles, if_a.fault, if_a.fault_code);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp_a, got_a;
    logic [14:0] exp_b, got_b;
    for (int i = 0; i < 4000; i++) begin
      int r = int'($urandom_range(0, 99));
      int ref_phase = (i % 2 == 0) ? ma.phase : mb.phase;
      int light = (r < 55) ? ref_phase : (r < 95) ? (ref_phase + 1) % 3 : int'($urandom_range(0, 3));
      bit en  = ($urandom_range(0, 9) != 0);
      bit clr = ($urandom_range(0, 19) == 0);
      bit rst = ($urandom_range(0, 199) == 0);
      drive(light, en, clr, rst);
      exp_a = {2'(ma.phase), ma.valid, 8'(ma.dwell), 16'(ma.cycles), ma.fault, 3'(ma.code), ma.pulse, safe_of(ma)};
      got_a = {if_a.phase, if_a.phase_valid, if_a.dwell, if_a.cycles, if_a.fault, if_a.fault_code,
               if_a.err_pulse, if_a.safe_to_cross};
      n_checks++;
      if (got_a !== exp_a) begin
        n_fail++; $display("FAIL random_a cycle %0d: got %h want %h", i, got_a, exp_a);
      end
      exp_b = {2'(mb.phase), mb.valid, 4'(mb.dwell), 2'(mb.cycles), mb.fault, 3'(mb.code), mb.pulse, safe_of(mb)};
      got_b = {if_b.phase, if_b.phase_valid, if_b.dwell, if_b.cycles, if_b.fault, if_b.fault_code,
               if_b.err_pulse, if_b.safe_to_cross};
      n_checks++;
      if (got_b !== exp_b) begin
        n_fail++; $display("FAIL random_b cycle %0d: got %h want %h", i, got_b, exp_b);
      end
    end
  endtask

  initial begin
    ma = '{0, 0, 0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0, 0, 0};
    reset = 1'b1;
    if_a.light_in = 2'd0; if_a.en = 1'b0; if_a.clear_fault = 1'b0;
    if_b.light_in = 2'd0; if_b.en = 1'b0; if_b.clear_fault = 1'b0;
    test_reset();
    test_full_cycles();
    test_illegal_code();
    test_bad_transition();
    test_timeout();
    test_en_gating();
    test_cycle_wrap();
    test_reset_in_fault();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
